// File: rtl/led_pixel_bit_selector_pkg.sv
// -----------------------------------------------------------------------------
// led_pixel_bit_selector_pkg
// Shared constants for the LED pixel/bit selector slice: colour and frame
// geometry, need-bar row assignments and the lit colour of each need bar.
// No ports (package).
// -----------------------------------------------------------------------------
package led_pixel_bit_selector_pkg;

    localparam int COLOR_W   = 24;   // GRB, MSB sent first
    localparam int FRAME_PIX = 64;   // animation pixels 0..63
    localparam int TOTAL_PIX = 128;  // 64..127 form the need-bar region
    localparam int LEVEL_W   = 3;    // need level width (0..7)
    localparam int PIX_IDX_W = $clog2(TOTAL_PIX);

    // Bar-region row that displays each need
    localparam logic [2:0] NEED_ROW_SALUD           = 3'd0;
    localparam logic [2:0] NEED_ROW_ALIMENTACION    = 3'd1;
    localparam logic [2:0] NEED_ROW_ENERGIA         = 3'd2;
    localparam logic [2:0] NEED_ROW_ENTRETENIMIENTO = 3'd3;
    localparam logic [2:0] NEED_ROW_HIGIENE         = 3'd4;

    // Lit bar colours, GRB ordering
    localparam logic [COLOR_W-1:0] COLOR_SALUD           = 24'h001000; // red
    localparam logic [COLOR_W-1:0] COLOR_ALIMENTACION    = 24'h100000; // green
    localparam logic [COLOR_W-1:0] COLOR_ENERGIA         = 24'h101000; // yellow
    localparam logic [COLOR_W-1:0] COLOR_ENTRETENIMIENTO = 24'h000010; // blue
    localparam logic [COLOR_W-1:0] COLOR_HIGIENE         = 24'h100010; // cyan

    // A bar column is lit when it lies below the level, so level 7 lights
    // columns 0..6 and column 7 can never light.
    function automatic logic bar_lit(input logic [LEVEL_W-1:0] col,
                                     input logic [LEVEL_W-1:0] level);
        return (col < level);
    endfunction

endpackage

// File: rtl/led_pixel_bit_selector_if.sv
// -----------------------------------------------------------------------------
// led_pixel_bit_selector_if
// Bundles the selector's pixel/bit indices, frame and colour inputs, the five
// need levels and the three registered results.
//   master : drives indices, frame_data, anim_color and levels; reads results
//   slave  : the selector itself
// -----------------------------------------------------------------------------
interface led_pixel_bit_selector_if;
    import led_pixel_bit_selector_pkg::*;

    logic [PIX_IDX_W-1:0] pixel_idx;
    logic [4:0]           bit_idx;
    logic [FRAME_PIX-1:0] frame_data;
    logic [COLOR_W-1:0]   anim_color;
    logic [LEVEL_W-1:0]   salud;
    logic [LEVEL_W-1:0]   alimentacion;
    logic [LEVEL_W-1:0]   energia;
    logic [LEVEL_W-1:0]   entretenimiento;
    logic [LEVEL_W-1:0]   higiene;
    logic                 pixel_active;
    logic [COLOR_W-1:0]   need_color;
    logic                 bit_out;

    modport master (
        output pixel_idx, bit_idx, frame_data, anim_color,
               salud, alimentacion, energia, entretenimiento, higiene,
        input  pixel_active, need_color, bit_out
    );

    modport slave (
        input  pixel_idx, bit_idx, frame_data, anim_color,
               salud, alimentacion, energia, entretenimiento, higiene,
        output pixel_active, need_color, bit_out
    );

endinterface

// File: rtl/led_pixel_bit_selector_need_bar_color.sv
// -----------------------------------------------------------------------------
// led_pixel_bit_selector_need_bar_color
// Combinational colour of a pixel in the need-bar region.
//   pixel_idx_i       : pixel index 0..127 (animation pixels give black)
//   salud_i .. higiene_i : need levels 0..7
//   color_o           : GRB colour of the bar pixel, 0 when unlit
// -----------------------------------------------------------------------------
module led_pixel_bit_selector_need_bar_color
    import led_pixel_bit_selector_pkg::*;
(
    input  logic [PIX_IDX_W-1:0] pixel_idx_i,
    input  logic [LEVEL_W-1:0]   salud_i,
    input  logic [LEVEL_W-1:0]   alimentacion_i,
    input  logic [LEVEL_W-1:0]   energia_i,
    input  logic [LEVEL_W-1:0]   entretenimiento_i,
    input  logic [LEVEL_W-1:0]   higiene_i,
    output logic [COLOR_W-1:0]   color_o
);

    logic               in_bar;
    logic [2:0]         row;
    logic [2:0]         col;
    logic [LEVEL_W-1:0] level;
    logic [COLOR_W-1:0] lit_color;

    // The bar region starts at 64, so pixel_idx - 64 is just the low six
    // bits: row in [5:3], column in [2:0].
    assign in_bar = pixel_idx_i[6];
    assign row    = pixel_idx_i[5:3];
    assign col    = pixel_idx_i[2:0];

    // Rows 5..7 carry no need; a zero level keeps them dark.
    always_comb begin
        level     = '0;
        lit_color = '0;
        case (row)
            NEED_ROW_SALUD: begin
                level     = salud_i;
                lit_color = COLOR_SALUD;
            end
            NEED_ROW_ALIMENTACION: begin
                level     = alimentacion_i;
                lit_color = COLOR_ALIMENTACION;
            end
            NEED_ROW_ENERGIA: begin
                level     = energia_i;
                lit_color = COLOR_ENERGIA;
            end
            NEED_ROW_ENTRETENIMIENTO: begin
                level     = entretenimiento_i;
                lit_color = COLOR_ENTRETENIMIENTO;
            end
            NEED_ROW_HIGIENE: begin
                level     = higiene_i;
                lit_color = COLOR_HIGIENE;
            end
            default: begin
                level     = '0;
                lit_color = '0;
            end
        endcase
    end

    assign color_o = (in_bar && bar_lit(col, level)) ? lit_color : '0;

endmodule

// File: rtl/led_pixel_bit_selector.sv
// -----------------------------------------------------------------------------
// led_pixel_bit_selector
// Registered datapath in front of the 16x8 WS2812 serializer. For the current
// pixel and colour bit it registers whether the animation pixel is lit, the
// need-bar colour and the single serial bit to drive out (1-cycle latency).
//   clk : system clock
//   rst : synchronous active-high reset, clears all outputs
//   bus : slave side of led_pixel_bit_selector_if
// -----------------------------------------------------------------------------
module led_pixel_bit_selector
    import led_pixel_bit_selector_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    led_pixel_bit_selector_if.slave  bus
);

    logic               in_frame;
    logic [COLOR_W-1:0] bar_color;
    logic [COLOR_W-1:0] color_sel;

    logic               pixel_active_d, pixel_active_q;
    logic [COLOR_W-1:0] need_color_d,   need_color_q;
    logic               bit_out_d,      bit_out_q;

    led_pixel_bit_selector_need_bar_color u_need_bar_color (
        .pixel_idx_i       (bus.pixel_idx),
        .salud_i           (bus.salud),
        .alimentacion_i    (bus.alimentacion),
        .energia_i         (bus.energia),
        .entretenimiento_i (bus.entretenimiento),
        .higiene_i         (bus.higiene),
        .color_o           (bar_color)
    );

    // FRAME_PIX is 64, so the animation region is exactly pixel_idx[6] == 0.
    assign in_frame = ~bus.pixel_idx[6];

    // Bit 0 of the index is the first bit on the wire, i.e. colour bit 23.
    // Indices 24..31 fall outside the colour and send a zero.
    always_comb begin
        color_sel      = in_frame ? bus.anim_color : bar_color;
        pixel_active_d = in_frame ? bus.frame_data[bus.pixel_idx[5:0]] : 1'b0;
        need_color_d   = bar_color;
        bit_out_d      = 1'b0;
        if (bus.bit_idx <= 5'd23) begin
            bit_out_d = color_sel[5'd23 - bus.bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_active_q <= 1'b0;
            need_color_q   <= '0;
            bit_out_q      <= 1'b0;
        end else begin
            pixel_active_q <= pixel_active_d;
            need_color_q   <= need_color_d;
            bit_out_q      <= bit_out_d;
        end
    end

    assign bus.pixel_active = pixel_active_q;
    assign bus.need_color   = need_color_q;
    assign bus.bit_out      = bit_out_q;

endmodule

// File: tb/tb_led_pixel_bit_selector.sv
// -----------------------------------------------------------------------------
// tb_led_pixel_bit_selector
// Directed-vector bench for led_pixel_bit_selector with hand-computed results.
// -----------------------------------------------------------------------------
module tb_led_pixel_bit_selector;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    led_pixel_bit_selector_if bus ();

    led_pixel_bit_selector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it before sampling.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_levels();
        bus.salud           = 3'd0;
        bus.alimentacion    = 3'd0;
        bus.energia         = 3'd0;
        bus.entretenimiento = 3'd0;
        bus.higiene         = 3'd0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.frame_data = {64{1'b1}};
        bus.pixel_idx  = 7'd0;
        bus.bit_idx    = 5'd0;
        bus.anim_color = 24'hFFFFFF;
        clear_levels();
        applyStimulus();
        vectors++;
        if (bus.pixel_active !== 1'b0 || bus.need_color !== 24'h0 || bus.bit_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: pixel_active=%b need_color=%h bit_out=%b, required 0/000000/0",
                     bus.pixel_active, bus.need_color, bus.bit_out);
        end
        rst = 1'b0;
        applyStimulus();
        vectors++;
        if (bus.pixel_active !== 1'b1 || bus.bit_out !== 1'b1 || bus.need_color !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: pixel_active=%b bit_out=%b need_color=%h, required 1/1/000000",
                     bus.pixel_active, bus.bit_out, bus.need_color);
        end
    endtask

    task automatic test_pixel_mux();
        logic [6:0] idx [4]  = '{7'd0, 7'd63, 7'd1, 7'd100};
        logic       exp [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.frame_data = 64'h8000_0000_0000_0001;
        bus.anim_color = 24'h000000;
        for (int i = 0; i < 4; i++) begin
            bus.pixel_idx = idx[i];
            applyStimulus();
            vectors++;
            if (bus.pixel_active !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL pixel_mux idx=%0d: got %b, required %b",
                         idx[i], bus.pixel_active, exp[i]);
            end
            if (idx[i] < 7'd64) begin
                vectors++;
                if (bus.need_color !== 24'h0) begin
                    miscompares++;
                    $display("[TB] FAIL frame_need_color idx=%0d: got %h, required 000000",
                             idx[i], bus.need_color);
                end
            end
        end
    endtask

    task automatic test_bit_order();
        logic [4:0] bidx [4] = '{5'd0, 5'd1, 5'd23, 5'd24};
        logic       exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.pixel_idx  = 7'd5;
        bus.anim_color = 24'h800001;
        for (int i = 0; i < 4; i++) begin
            bus.bit_idx = bidx[i];
            applyStimulus();
            vectors++;
            if (bus.bit_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL bit_order bit_idx=%0d: got %b, required %b",
                         bidx[i], bus.bit_out, exp[i]);
            end
        end
        bus.anim_color = 24'hFFFFFF;
        bus.bit_idx    = 5'd31;
        applyStimulus();
        vectors++;
        if (bus.bit_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bit_order_31: got %b, required 0", bus.bit_out);
        end
    endtask

    task automatic test_bars();
        logic [6:0]  idx [9] = '{7'd64, 7'd65, 7'd66, 7'd67, 7'd72, 7'd73, 7'd74, 7'd88, 7'd89};
        logic [23:0] exp [9] = '{24'h001000, 24'h001000, 24'h001000, 24'h000000,
                                 24'h100000, 24'h100000, 24'h000000, 24'h000010, 24'h000000};
        clear_levels();
        bus.salud = 3'd3;
        // Row 1 first with level 0 -> dark
        bus.pixel_idx = 7'd72;
        bus.bit_idx   = 5'd0;
        applyStimulus();
        vectors++;
        if (bus.need_color !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL bars_row1_empty: got %h, required 000000", bus.need_color);
        end
        bus.alimentacion    = 3'd2;
        bus.entretenimiento = 3'd1;
        for (int i = 0; i < 9; i++) begin
            bus.pixel_idx = idx[i];
            applyStimulus();
            vectors++;
            if (bus.need_color !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL bars idx=%0d: got %h, required %h",
                         idx[i], bus.need_color, exp[i]);
            end
        end
    endtask

    task automatic test_bar_extremes();
        logic [23:0] exp;
        clear_levels();
        bus.higiene = 3'd7;
        bus.bit_idx = 5'd3;
        for (int p = 96; p <= 103; p++) begin
            bus.pixel_idx = 7'(p);
            exp = (p <= 102) ? 24'h100010 : 24'h000000;
            applyStimulus();
            vectors++;
            if (bus.need_color !== exp) begin
                miscompares++;
                $display("[TB] FAIL bar_extreme idx=%0d: got %h, required %h", p, bus.need_color, exp);
            end
            // bit_idx 3 selects colour bit 20, set in cyan
            vectors++;
            if (bus.bit_out !== (p <= 102)) begin
                miscompares++;
                $display("[TB] FAIL bar_extreme_bit idx=%0d: got %b, required %b",
                         p, bus.bit_out, (p <= 102));
            end
        end
        bus.salud           = 3'd7;
        bus.alimentacion    = 3'd7;
        bus.energia         = 3'd7;
        bus.entretenimiento = 3'd7;
        for (int p = 104; p <= 127; p += 23) begin
            bus.pixel_idx = 7'(p);
            applyStimulus();
            vectors++;
            if (bus.need_color !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL unused_row idx=%0d: got %h, required 000000", p, bus.need_color);
            end
        end
    endtask

    task automatic test_bar_serialization();
        logic [23:0] golden = 24'h101000;
        clear_levels();
        bus.energia    = 3'd1;
        bus.pixel_idx  = 7'd80;
        bus.anim_color = 24'h000000;
        for (int i = 0; i < 24; i++) begin
            bus.bit_idx = 5'(i);
            applyStimulus();
            vectors++;
            if (bus.bit_out !== golden[23-i]) begin
                miscompares++;
                $display("[TB] FAIL serialize bit_idx=%0d: got %b, required %b",
                         i, bus.bit_out, golden[23-i]);
            end
        end
    endtask

    // Inputs that change between edges must not show until the next edge,
    // and reset must win over live inputs.
    task automatic test_back_to_back();
        bus.frame_data = 64'h0000_0000_0000_0004;
        bus.anim_color = 24'h400000;
        bus.pixel_idx  = 7'd2;
        bus.bit_idx    = 5'd1;
        applyStimulus();
        vectors++;
        if (bus.pixel_active !== 1'b1 || bus.bit_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: pixel_active=%b bit_out=%b, required 1/1",
                     bus.pixel_active, bus.bit_out);
        end
        bus.pixel_idx = 7'd3;
        bus.bit_idx   = 5'd2;
        #2;
        vectors++;
        if (bus.pixel_active !== 1'b1 || bus.bit_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold: pixel_active=%b bit_out=%b, required 1/1 before edge",
                     bus.pixel_active, bus.bit_out);
        end
        applyStimulus();
        vectors++;
        if (bus.pixel_active !== 1'b0 || bus.bit_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: pixel_active=%b bit_out=%b, required 0/0",
                     bus.pixel_active, bus.bit_out);
        end
        bus.pixel_idx = 7'd2;
        bus.bit_idx   = 5'd1;
        clear_levels();
        rst = 1'b1;
        applyStimulus();
        vectors++;
        if (bus.pixel_active !== 1'b0 || bus.bit_out !== 1'b0 || bus.need_color !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL b2b_reset: pixel_active=%b bit_out=%b need_color=%h, required 0/0/000000",
                     bus.pixel_active, bus.bit_out, bus.need_color);
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_pixel_mux();
        test_bit_order();
        test_bars();
        test_bar_extremes();
        test_bar_serialization();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
